// File: rtl/fetch_sequencer.sv
// Command-level controller for the data-fetch unit: accepts one load/store command,
// drives the fetch controls through clear -> run -> finish and pulses completion.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [2:0]  CMD_OP,
    input  logic [16:0] CMD_ADDR,
    input  logic [1:0]  CMD_DIMEN,
    input  logic [1:0]  CMD_PESEL,
    output logic [1:0]  DIMEN,
    output logic [16:0] ADDRESS,
    output logic        ADDR_RST,
    output logic        ADDR_START,
    output logic        WRADDR_START,
    output logic [1:0]  PE_SEL,
    output logic        PE_SEL_2x2,
    output logic        PE_SEL_4,
    input  logic        FETCH_DONE,
    input  logic        STORE_DONE,
    output logic        BUSY,
    output logic        CMD_DONE,
    output logic [1:0]  ERR
);

    localparam logic [2:0] OP_LOAD_PE = 3'd1;
    localparam logic [2:0] OP_LOADA   = 3'd2;
    localparam logic [2:0] OP_LOADB   = 3'd3;
    localparam logic [2:0] OP_STORE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {StIdle, StClr, StRunLd, StRunSt, StFin} state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;

    // cnt_q holds the number of RUN cycles already completed before the current one.
    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            op_q         <= 3'd0;
            cnt_q        <= '0;
            CMD_READY    <= 1'b0;
            BUSY         <= 1'b0;
            CMD_DONE     <= 1'b0;
            ADDR_RST     <= 1'b1;
            ADDR_START   <= 1'b0;
            WRADDR_START <= 1'b0;
            DIMEN        <= 2'd0;
            ADDRESS      <= 17'd0;
            PE_SEL       <= 2'd0;
            PE_SEL_2x2   <= 1'b0;
            PE_SEL_4     <= 1'b0;
            ERR          <= 2'b00;
        end else begin
            CMD_DONE <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (CMD_VALID && CMD_READY) begin
                        op_q      <= CMD_OP;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        ADDR_RST  <= 1'b1;
                        if (CMD_OP <= OP_STORE) begin
                            state_q <= StClr;
                            DIMEN   <= CMD_DIMEN;
                            ADDRESS <= CMD_ADDR;
                            case (CMD_OP)
                                OP_LOAD_PE: begin
                                    PE_SEL     <= 2'd1;
                                    PE_SEL_4   <= CMD_PESEL[1];
                                    PE_SEL_2x2 <= CMD_PESEL[0];
                                end
                                OP_LOADA: begin
                                    PE_SEL     <= 2'd2;
                                    PE_SEL_2x2 <= CMD_PESEL[0];
                                end
                                OP_LOADB: begin
                                    PE_SEL     <= 2'd3;
                                    PE_SEL_2x2 <= CMD_PESEL[0];
                                end
                                default: begin
                                    PE_SEL     <= 2'd0;
                                    PE_SEL_2x2 <= 1'b0;
                                    PE_SEL_4   <= 1'b0;
                                end
                            endcase
                        end else begin
                            // Illegal opcode skips the fetch entirely but still completes.
                            state_q  <= StFin;
                            CMD_DONE <= 1'b1;
                            ERR[1]   <= 1'b1;
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                        ADDR_RST  <= 1'b0;
                    end
                end

                StClr: begin
                    ADDR_RST   <= 1'b0;
                    ADDR_START <= 1'b1;
                    cnt_q      <= '0;
                    if (op_q == OP_STORE) begin
                        state_q      <= StRunSt;
                        WRADDR_START <= 1'b1;
                    end else begin
                        state_q <= StRunLd;
                    end
                end

                StRunLd: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (FETCH_DONE || timeout) begin
                        state_q    <= StFin;
                        ADDR_START <= 1'b0;
                        ADDR_RST   <= 1'b1;
                        CMD_DONE   <= 1'b1;
                        if (!FETCH_DONE) begin
                            ERR[0] <= 1'b1;
                        end
                    end
                end

                StRunSt: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (STORE_DONE || timeout) begin
                        state_q      <= StFin;
                        ADDR_START   <= 1'b0;
                        WRADDR_START <= 1'b0;
                        ADDR_RST     <= 1'b1;
                        CMD_DONE     <= 1'b1;
                        if (!STORE_DONE) begin
                            ERR[0] <= 1'b1;
                        end
                    end
                end

                StFin: begin
                    state_q    <= StIdle;
                    CMD_READY  <= 1'b1;
                    BUSY       <= 1'b0;
                    ADDR_RST   <= 1'b0;
                    DIMEN      <= 2'd0;
                    ADDRESS    <= 17'd0;
                    PE_SEL     <= 2'd0;
                    PE_SEL_2x2 <= 1'b0;
                    PE_SEL_4   <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: expected per-cycle output traces built from the command
// rules, a behavioural fetch unit, and a per-cycle compare process.
module tb_fetch_sequencer;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic [2:0]  CMD_OP = 3'd0;
    logic [16:0] CMD_ADDR = 17'd0;
    logic [1:0]  CMD_DIMEN = 2'd0;
    logic [1:0]  CMD_PESEL = 2'd0;
    logic        FETCH_DONE = 1'b0;
    logic        STORE_DONE = 1'b0;
    logic        CMD_READY, ADDR_RST, ADDR_START, WRADDR_START;
    logic        PE_SEL_2x2, PE_SEL_4, BUSY, CMD_DONE;
    logic [1:0]  DIMEN, PE_SEL, ERR;
    logic [16:0] ADDRESS;

    fetch_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP),
        .CMD_ADDR(CMD_ADDR),
        .CMD_DIMEN(CMD_DIMEN),
        .CMD_PESEL(CMD_PESEL),
        .DIMEN(DIMEN),
        .ADDRESS(ADDRESS),
        .ADDR_RST(ADDR_RST),
        .ADDR_START(ADDR_START),
        .WRADDR_START(WRADDR_START),
        .PE_SEL(PE_SEL),
        .PE_SEL_2x2(PE_SEL_2x2),
        .PE_SEL_4(PE_SEL_4),
        .FETCH_DONE(FETCH_DONE),
        .STORE_DONE(STORE_DONE),
        .BUSY(BUSY),
        .CMD_DONE(CMD_DONE),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ready, busy, done, arst, astart, wstart;
        logic [1:0]  err;
        logic        data;
        logic [1:0]  dimen;
        logic [16:0] addr;
        logic [1:0]  pesel;
        logic        sel2, sel4;
    } vec_t;

    vec_t       exp_q[$];
    logic [1:0] err_model = 2'b00;
    bit         checking = 0, fetch_en = 1, stray_fetch = 0, stray_store = 0;
    int         tests = 0, fails = 0;
    int         fcnt = 0, scnt = 0;
    int         lat = 0, alen = 0, wlen = 0, done_cnt = 0;
    int         last_lat = 0, last_alen = 0, last_wlen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t ctl(bit ready, bit busy, bit done, bit arst, bit astart,
                                 bit wstart, logic [1:0] err);
        vec_t v;
        v.ready = ready; v.busy = busy; v.done = done; v.arst = arst;
        v.astart = astart; v.wstart = wstart; v.err = err;
        v.data = 1'b0; v.dimen = 2'd0; v.addr = 17'd0; v.pesel = 2'd0;
        v.sel2 = 1'b0; v.sel4 = 1'b0;
        return v;
    endfunction

    // Routing table: what DIMEN/ADDRESS/PE_SEL* must show from CLR through FIN.
    function automatic vec_t route(vec_t c, logic [2:0] op, logic [16:0] addr,
                                   logic [1:0] dimen, logic [1:0] pesel);
        vec_t v = c;
        v.data = 1'b1; v.dimen = dimen; v.addr = addr;
        v.pesel = 2'd0; v.sel2 = 1'b0; v.sel4 = 1'b0;
        case (op)
            3'd1: begin v.pesel = 2'd1; v.sel4 = pesel[1]; v.sel2 = pesel[0]; end
            3'd2: begin v.pesel = 2'd2; v.sel2 = pesel[0]; end
            3'd3: begin v.pesel = 2'd3; v.sel2 = pesel[0]; end
            default: ;
        endcase
        return v;
    endfunction

    // Expected trace from the accept cycle to the FIN cycle of one command.
    task automatic push_cmd(input logic [2:0] op, input logic [16:0] addr,
                            input logic [1:0] dimen, input logic [1:0] pesel);
        int len;
        bit tmo;
        exp_q.push_back(ctl(1, 0, 0, 0, 0, 0, err_model));
        if (op > 3'd4) begin
            err_model[1] = 1'b1;
            exp_q.push_back(ctl(0, 1, 1, 1, 0, 0, err_model));
            return;
        end
        if (op == 3'd4) len = 4;
        else if (fetch_en) len = 3 * (2 << dimen);
        else len = TO + 1;
        tmo = (len > TO);
        if (tmo) len = TO;
        exp_q.push_back(route(ctl(0, 1, 0, 1, 0, 0, err_model), op, addr, dimen, pesel));
        for (int i = 0; i < len; i++)
            exp_q.push_back(route(ctl(0, 1, 0, 0, 1, op == 3'd4, err_model),
                                  op, addr, dimen, pesel));
        if (tmo) err_model[0] = 1'b1;
        exp_q.push_back(route(ctl(0, 1, 1, 1, 0, 0, err_model), op, addr, dimen, pesel));
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic issue(input logic [2:0] op, input logic [16:0] addr,
                         input logic [1:0] dimen, input logic [1:0] pesel);
        wait_empty("pre_issue_drain");
        CMD_OP = op; CMD_ADDR = addr; CMD_DIMEN = dimen; CMD_PESEL = pesel;
        CMD_VALID = 1'b1;
        push_cmd(op, addr, dimen, pesel);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    // Behavioural fetch unit: one word per 3 enabled cycles; store writes one word per cycle.
    always @(negedge CLK) begin
        if (ADDR_RST === 1'b1) begin
            fcnt = 0;
            scnt = 0;
        end else begin
            if (ADDR_START === 1'b1 && WRADDR_START === 1'b0) fcnt++;
            if (ADDR_START === 1'b1 && WRADDR_START === 1'b1) scnt++;
        end
        FETCH_DONE = stray_fetch || (fetch_en && ADDR_START === 1'b1 &&
                     WRADDR_START === 1'b0 && fcnt == 3 * (2 << DIMEN));
        STORE_DONE = stray_store || (ADDR_START === 1'b1 && WRADDR_START === 1'b1 && scnt == 4);
    end

    always @(negedge CLK) begin : compare
        vec_t e;
        if (checking) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = ctl(1, 0, 0, 0, 0, 0, err_model);
            chk("CMD_READY", CMD_READY, e.ready);
            chk("BUSY", BUSY, e.busy);
            chk("CMD_DONE", CMD_DONE, e.done);
            chk("ADDR_RST", ADDR_RST, e.arst);
            chk("ADDR_START", ADDR_START, e.astart);
            chk("WRADDR_START", WRADDR_START, e.wstart);
            chk("ERR", ERR, e.err);
            if (e.data) begin
                chk("DIMEN", DIMEN, e.dimen);
                chk("ADDRESS", ADDRESS, e.addr);
                chk("PE_SEL", PE_SEL, e.pesel);
                chk("PE_SEL_2x2", PE_SEL_2x2, e.sel2);
                chk("PE_SEL_4", PE_SEL_4, e.sel4);
            end
            if (BUSY === 1'b1) lat++;
            if (ADDR_START === 1'b1) alen++;
            if (WRADDR_START === 1'b1) wlen++;
            if (CMD_DONE === 1'b1) begin
                done_cnt++;
                last_lat = lat; last_alen = alen; last_wlen = wlen;
                lat = 0; alen = 0; wlen = 0;
            end
            if (RST) begin
                lat = 0; alen = 0; wlen = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d0;
        RST = 1'b1;
        @(posedge CLK); #1;
        checking = 1;
        repeat (3) exp_q.push_back(ctl(0, 0, 0, 1, 0, 0, 2'b00));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_empty("reset_drain");
        chk("reset_no_done", done_cnt, 0);

        // Broadcast 2x2 load; a stray STORE_DONE must not end RUN_LD.
        stray_store = 1;
        issue(3'd0, 17'h00100, 2'd0, 2'd0);
        wait_empty("bcast_drain");
        stray_store = 0;
        chk("bcast_accept_to_done", last_lat, 8);
        chk("bcast_astart_len", last_alen, 6);

        // LOAD_PE 4x4, with a CMD_VALID pulse while busy that must be ignored.
        issue(3'd1, 17'h000A5, 2'd1, 2'd2);
        CMD_OP = 3'd0; CMD_ADDR = 17'h1FFFF; CMD_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        wait_empty("load_pe_drain");
        chk("load_pe_astart_len", last_alen, 12);
        chk("load_pe_done_count", done_cnt, 2);

        // Store; a stray FETCH_DONE must not end RUN_ST.
        stray_fetch = 1;
        issue(3'd4, 17'h00040, 2'd2, 2'd3);
        wait_empty("store_drain");
        stray_fetch = 0;
        chk("store_astart_len", last_alen, 4);
        chk("store_wstart_len", last_wlen, 4);
        chk("store_err", ERR, 2'b00);

        // Timeout with FETCH_DONE held low, then normal commands keep ERR sticky.
        fetch_en = 0;
        issue(3'd0, 17'h12345, 2'd0, 2'd0);
        wait_empty("timeout_drain");
        fetch_en = 1;
        chk("timeout_astart_len", last_alen, 16);
        chk("timeout_err", ERR, 2'b01);
        issue(3'd2, 17'h00200, 2'd0, 2'd1);
        wait_empty("loada_drain");
        chk("loada_astart_len", last_alen, 6);
        chk("loada_err_sticky", ERR, 2'b01);
        issue(3'd3, 17'h00300, 2'd1, 2'd3);
        wait_empty("loadb_drain");
        chk("loadb_astart_len", last_alen, 12);

        // Illegal opcode.
        issue(3'd6, 17'h00777, 2'd1, 2'd1);
        wait_empty("illegal_drain");
        chk("illegal_astart_len", last_alen, 0);
        chk("illegal_busy_cycles", last_lat, 1);
        chk("illegal_err", ERR, 2'b11);

        // Reset during RUN_LD drops the command without CMD_DONE and clears ERR.
        d0 = done_cnt;
        CMD_OP = 3'd0; CMD_ADDR = 17'h00ABC; CMD_DIMEN = 2'd1; CMD_PESEL = 2'd0;
        CMD_VALID = 1'b1;
        exp_q.push_back(ctl(1, 0, 0, 0, 0, 0, err_model));
        exp_q.push_back(route(ctl(0, 1, 0, 1, 0, 0, err_model), 3'd0, 17'h00ABC, 2'd1, 2'd0));
        repeat (3)
            exp_q.push_back(route(ctl(0, 1, 0, 0, 1, 0, err_model),
                                  3'd0, 17'h00ABC, 2'd1, 2'd0));
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        err_model = 2'b00;
        exp_q.push_back(ctl(0, 0, 0, 1, 0, 0, 2'b00));
        @(posedge CLK); #1;
        RST = 1'b0;
        wait_empty("rst_mid_drain");
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_err", ERR, 2'b00);

        issue(3'd0, 17'h00010, 2'd0, 2'd0);
        wait_empty("recover_drain");
        chk("recover_astart_len", last_alen, 6);
        repeat (3) @(posedge CLK);
        #1;
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
